// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - Synchronised, debounced active-low key inputs with press/release/long-press pulses
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n        raw key pins, asynchronous, 0 = pressed
//   key_state    debounced level per key, 1 = pressed
//   key_press    one-cycle pulse when a press is confirmed
//   key_release  one-cycle pulse when a release is confirmed
//   key_long     one-cycle pulse when a press has lasted LONG_CNT cycles in HELD

module key_debounce #(
    parameter int N_KEYS      = 4,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_US = 20_000,
    parameter int LONG_MS     = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam logic [31:0] DB_CNT   = 32'((CLK_FREQ_HZ / 1_000_000) * DEBOUNCE_US);
    localparam logic [31:0] LONG_CNT = 32'((CLK_FREQ_HZ / 1000) * LONG_MS);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic        sync1;
        logic        sync2;
        logic        s;
        state_t      state;
        logic [31:0] dcnt;
        logic [31:0] lcnt;
        logic        state_r;
        logic        press_r;
        logic        release_r;
        logic        long_r;

        // Synchroniser idles at 1 so a reset looks like a released key.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= key_n[k];
                sync2 <= sync1;
            end
        end

        assign s = ~sync2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                dcnt      <= '0;
                lcnt      <= '0;
                state_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s) begin
                            state <= PRESS_WAIT;
                            dcnt  <= 32'd1;
                        end else begin
                            dcnt  <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s) begin
                            state <= IDLE;
                            dcnt  <= '0;
                        end else if (dcnt == DB_CNT - 32'd1) begin
                            state   <= HELD;
                            dcnt    <= '0;
                            lcnt    <= '0;
                            state_r <= 1'b1;
                            press_r <= 1'b1;
                        end else begin
                            dcnt <= dcnt + 32'd1;
                        end
                    end
                    HELD: begin
                        // Saturating count; the pulse fires only on the step that reaches
                        // LONG_CNT, so a held key never auto-repeats.
                        if (lcnt < LONG_CNT) begin
                            lcnt <= lcnt + 32'd1;
                            if (lcnt == LONG_CNT - 32'd1) begin
                                long_r <= 1'b1;
                            end
                        end
                        if (!s) begin
                            state <= RELEASE_WAIT;
                            dcnt  <= 32'd1;
                        end
                    end
                    RELEASE_WAIT: begin
                        // lcnt is left untouched here so release bounce neither
                        // restarts nor advances the long-press timer.
                        if (s) begin
                            state <= HELD;
                            dcnt  <= '0;
                        end else if (dcnt == DB_CNT - 32'd1) begin
                            state     <= IDLE;
                            dcnt      <= '0;
                            state_r   <= 1'b0;
                            release_r <= 1'b1;
                        end else begin
                            dcnt <= dcnt + 32'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end
                endcase
            end
        end

        assign key_state[k]   = state_r;
        assign key_press[k]   = press_r;
        assign key_release[k] = release_r;
        assign key_long[k]    = long_r;
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - Self-checking bench for key_debounce against a run-length reference model

module tb_key_debounce;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int LC = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_n;
    logic [N-1:0] key_state;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;

    key_debounce #(
        .N_KEYS      (N),
        .CLK_FREQ_HZ (1_000_000),
        .DEBOUNCE_US (8),
        .LONG_MS     (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: raw pins delayed two samples give s; the debounced level
    // flips once s has disagreed with it for DB consecutive samples. Long-press
    // time accumulates only on edges where the key is pressed with no pending
    // disagreement.
    bit           m_q1 [N];
    bit           m_q2 [N];
    bit           m_level [N];
    int           m_run [N];
    int           m_held [N];
    logic [N-1:0] e_state, e_press, e_rel, e_long;

    int cyc;
    int n_press [N];
    int n_rel [N];
    int n_long [N];
    int first_press [N];
    int first_rel [N];
    int first_long [N];
    bit saw_all_press;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_q1[k] = 1'b1; m_q2[k] = 1'b1; m_level[k] = 1'b0;
            m_run[k] = 0; m_held[k] = 0;
        end
        e_state = '0; e_press = '0; e_rel = '0; e_long = '0;
    endtask

    task automatic model_step();
        bit s;
        e_press = '0; e_rel = '0; e_long = '0;
        for (int k = 0; k < N; k++) begin
            s = ~m_q2[k];
            m_q2[k] = m_q1[k];
            m_q1[k] = key_n[k];
            if (m_level[k] && m_run[k] == 0 && m_held[k] < LC) begin
                m_held[k]++;
                if (m_held[k] == LC) e_long[k] = 1'b1;
            end
            if (s == m_level[k]) begin
                m_run[k] = 0;
            end else begin
                m_run[k]++;
                if (m_run[k] == DB) begin
                    m_level[k] = ~m_level[k];
                    m_run[k] = 0;
                    if (m_level[k]) begin
                        e_press[k] = 1'b1;
                        m_held[k] = 0;
                    end else begin
                        e_rel[k] = 1'b1;
                    end
                end
            end
            e_state[k] = m_level[k];
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        cyc = 0;
        saw_all_press = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0;
            first_press[k] = -1; first_rel[k] = -1; first_long[k] = -1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        check("key_state",   int'(key_state),   int'(e_state));
        check("key_press",   int'(key_press),   int'(e_press));
        check("key_release", int'(key_release), int'(e_rel));
        check("key_long",    int'(key_long),    int'(e_long));
        if (key_press == 4'hF) saw_all_press = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (key_press[k]) begin
                n_press[k]++;
                if (first_press[k] < 0) first_press[k] = cyc;
            end
            if (key_release[k]) begin
                n_rel[k]++;
                if (first_rel[k] < 0) first_rel[k] = cyc;
            end
            if (key_long[k]) begin
                n_long[k]++;
                if (first_long[k] < 0) first_long[k] = cyc;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int hold_left [N];

    initial begin
        rst_n = 1'b0;
        key_n = 4'hF;
        model_reset();
        clr_stats();
        #23;
        check("reset_state", int'(key_state), 0);
        check("reset_pulses", int'({key_press, key_release, key_long}), 0);
        run(2);
        rst_n = 1'b1;
        run(4);

        // Clean press on key 0
        clr_stats();
        key_n = 4'b1110;
        run(20);
        check("clean_press_edge", first_press[0], 9);
        check("clean_press_count", n_press[0], 1);
        check("clean_other_keys", n_press[1] + n_press[2] + n_press[3], 0);
        key_n = 4'hF;
        run(20);

        // Bounce rejection on key 1
        clr_stats();
        for (int i = 0; i < 40; i++) begin
            key_n[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        key_n[1] = 1'b1;
        run(15);
        check("bounce_no_press", n_press[1], 0);
        check("bounce_no_release", n_rel[1], 0);

        // Press bounce on key 2
        clr_stats();
        key_n[2] = 1'b0; run(5);
        key_n[2] = 1'b1; run(2);
        key_n[2] = 1'b0; run(20);
        check("press_bounce_count", n_press[2], 1);
        check("press_bounce_edge", first_press[2], 16);
        key_n[2] = 1'b1;
        run(20);

        // Long press and release on key 0
        clr_stats();
        key_n[0] = 1'b0; run(1100);
        key_n[0] = 1'b1; run(30);
        check("long_press_count", n_press[0], 1);
        check("long_pulse_count", n_long[0], 1);
        check("long_delay", first_long[0] - first_press[0], LC);
        check("long_release_count", n_rel[0], 1);
        check("long_release_edge", first_rel[0], 1109);
        check("long_state_end", int'(key_state[0]), 0);

        // Simultaneous presses
        clr_stats();
        key_n = 4'h0; run(20);
        check("simul_press", int'(saw_all_press), 1);
        key_n = 4'hF; run(20);

        // Reset while key 0 is held
        clr_stats();
        key_n[0] = 1'b0; run(30);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_state", int'(key_state), 0);
        check("rst_async_pulses", int'({key_press, key_release, key_long}), 0);
        run(3);
        rst_n = 1'b1;
        clr_stats();
        run(20);
        check("rst_fresh_press", first_press[0], 9);
        check("rst_no_release", n_rel[0], 0);
        key_n[0] = 1'b1;
        run(20);

        // Randomised: per key, hold durations mixing bounce, short and long holds
        for (int k = 0; k < N; k++) hold_left[k] = 1;
        for (int i = 0; i < 5000; i++) begin
            for (int k = 0; k < N; k++) begin
                hold_left[k]--;
                if (hold_left[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: hold_left[k] = $urandom_range(1, 9);
                        4, 5, 6, 7: hold_left[k] = $urandom_range(10, 60);
                        default:    hold_left[k] = $urandom_range(900, 1300);
                    endcase
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
